nano_run_monitor: RTL
=====================

Name: nano_run_monitor

Overview:
- Synthesizable run controller and result checker for the NanoRisc core; replaces the fixed 70-cycle, single-address (data[5]) check with a parametrised one.
- Gates the core with cpuEnable, counts cycles, detects a halt (PC stuck on a branch-to-self), snoops the data-memory write bus on NUM_WATCH addresses and reports pass/fail against expected values.
- Sits beside the core and the data memory; the bench or top level drives start and reads the status outputs.

Parameters:
DATA_WIDTH, 8, data-memory word width
ADDR_WIDTH, 4, data-memory address width
PC_WIDTH, 8, program counter width
CYCLE_WIDTH, 16, cycle counter width
MAX_CYCLES, 70, cycle budget (>=1, < 2^CYCLE_WIDTH)
NUM_WATCH, 2, number of watched data-memory addresses (>=1)
STALL_CYCLES, 4, consecutive unchanged-PC cycles that count as halt (>=1)

Ports:
clock  input  1  system clock, rising edge
resetN  input  1  synchronous active-low reset
start  input  1  one-cycle pulse: clear results and begin a run
pc  input  PC_WIDTH  core program counter
memWrite  input  1  core data-memory write strobe
memAddress  input  ADDR_WIDTH  core data-memory address
memWriteData  input  DATA_WIDTH  core data-memory write data
watchAddress  input  NUM_WATCH*ADDR_WIDTH  packed watch addresses, channel i at [i*ADDR_WIDTH +: ADDR_WIDTH]
expectedData  input  NUM_WATCH*DATA_WIDTH  packed expected values, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
cpuEnable  output  1  core clock-enable; high only in RUN
busy  output  1  high in RUN
done  output  1  high in DONE
timeout  output  1  run ended on cycle budget
halted  output  1  run ended on PC stall
pass  output  1  done, not timeout, every channel hit and matching
cycleCount  output  CYCLE_WIDTH  cycles executed in the current/last run
watchHit  output  NUM_WATCH  channel i has seen at least one write
watchData  output  NUM_WATCH*DATA_WIDTH  last value written to each watch address

Behaviour:
- Reset (resetN low at a rising edge): state IDLE; all outputs 0; internal prevPc, prevValid and stallCount cleared. Reset mid-run aborts the run with no result retained.
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE/DONE + start: enter RUN next cycle. Clear cycleCount to 0, watchHit, watchData, timeout, halted and prevValid. The start cycle itself does not count.
- RUN + start: ignored.
- RUN, every cycle:
  - cycleCount increments; the first RUN cycle shows 1 on the next edge.
  - For each channel i with memWrite=1 and memAddress==watchAddress[i]: watchData[i] <= memWriteData and watchHit[i] <= 1. The last write wins.
  - Several channels may share an address; all of them capture the write.
  - Writes with memWrite=0 or outside RUN are ignored.
- Halt detection:
  - prevPc <= pc every RUN cycle and prevValid <= 1.
  - If prevValid and pc==prevPc: stallCount increments, saturating at STALL_CYCLES; otherwise stallCount <= 0.
  - When the updated stallCount equals STALL_CYCLES: halted <= 1 and go to DONE.
- Timeout: when the updated cycleCount equals MAX_CYCLES and halt was not detected in that cycle: timeout <= 1 and go to DONE.
  - If halt and budget-exhaustion occur in the same cycle, halt wins: halted=1, timeout=0.
- Exit-cycle writes: a watch write in the cycle that enters DONE is captured.
- DONE:
  - cpuEnable=0 and all results hold.
  - pass = AND over i of (watchHit[i] and watchData[i]==expectedData[i]), and timeout=0. The comparison is registered on DONE entry using that cycle's expectedData.
  - expectedData is sampled only at DONE entry; later changes do not alter pass.
- cycleCount never wraps, because MAX_CYCLES < 2^CYCLE_WIDTH bounds it.

Test Plan:
- Reset with resetN=0 for 2 cycles, then hold idle with start=0 -> all outputs 0, cpuEnable=0 for 10 cycles.
- NUM_WATCH=2, watchAddress={4'd6,4'd5}, expected={8'd3,8'd21}. Start, write addr5=21 at cycle 10 and addr6=3 at cycle 12, then hold pc=0x20 constant from cycle 15 -> halted=1 at cycleCount 19, done=1, pass=1, timeout=0.
- Start, write addr5=9 then addr5=21, never write addr6, then stall the PC -> watchData[0]=21, watchHit=2'b01, pass=0.
- Increment pc every cycle with no stall -> timeout=1 at cycleCount=70, cpuEnable low from the next cycle, pass=0 even if all watches match.
- Make the stall complete exactly at cycle 70 -> halted=1, timeout=0. Assert start during RUN -> no effect.
- Assert resetN=0 at cycle 30 of a run -> IDLE with all outputs 0 next edge. A new start then runs cleanly with cycleCount restarting at 1.

Source files
------------

// File: rtl/nano_run_monitor_if.sv
`default_nettype none
// ============================================================================
// Module   : nano_run_monitor_if
// Purpose  : Control, memory-snoop and status bundle for nano_run_monitor.
// Revision : 1.0 - initial release
// ============================================================================
interface nano_run_monitor_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 4,
  parameter int PC_WIDTH    = 8,
  parameter int CYCLE_WIDTH = 16,
  parameter int NUM_WATCH   = 2
);
  logic                            start;
  logic [PC_WIDTH-1:0]             pc;
  logic                            memWrite;
  logic [ADDR_WIDTH-1:0]           memAddress;
  logic [DATA_WIDTH-1:0]           memWriteData;
  logic [NUM_WATCH*ADDR_WIDTH-1:0] watchAddress;
  logic [NUM_WATCH*DATA_WIDTH-1:0] expectedData;
  logic                            cpuEnable;
  logic                            busy;
  logic                            done;
  logic                            timeout;
  logic                            halted;
  logic                            pass;
  logic [CYCLE_WIDTH-1:0]          cycleCount;
  logic [NUM_WATCH-1:0]            watchHit;
  logic [NUM_WATCH*DATA_WIDTH-1:0] watchData;

  modport master (
    output start, pc, memWrite, memAddress, memWriteData, watchAddress, expectedData,
    input  cpuEnable, busy, done, timeout, halted, pass, cycleCount, watchHit, watchData
  );

  modport slave (
    input  start, pc, memWrite, memAddress, memWriteData, watchAddress, expectedData,
    output cpuEnable, busy, done, timeout, halted, pass, cycleCount, watchHit, watchData
  );
endinterface
`default_nettype wire

// File: rtl/nano_run_monitor.sv
`default_nettype none
// ============================================================================
// Module   : nano_run_monitor
// Purpose  : Gates the NanoRisc core, detects halt/timeout, checks watched writes.
// Revision : 1.0 - initial release
// ============================================================================
module nano_run_monitor #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 4,
  parameter int PC_WIDTH     = 8,
  parameter int CYCLE_WIDTH  = 16,
  parameter int MAX_CYCLES   = 70,
  parameter int NUM_WATCH    = 2,
  parameter int STALL_CYCLES = 4
) (
  input  wire logic               clock,
  input  wire logic               resetN,
  nano_run_monitor_if.slave       bus
);
  localparam int                     c_STALL_W = $clog2(STALL_CYCLES + 1);
  localparam logic [c_STALL_W-1:0]   c_STALL   = c_STALL_W'(STALL_CYCLES);
  localparam logic [CYCLE_WIDTH-1:0] c_MAX     = CYCLE_WIDTH'(MAX_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                          r_state;
  state_t                          w_state_nxt;
  logic [CYCLE_WIDTH-1:0]          r_cycle;
  logic [CYCLE_WIDTH-1:0]          w_cycle_inc;
  logic [PC_WIDTH-1:0]             r_prev_pc;
  logic                            r_prev_valid;
  logic [c_STALL_W-1:0]            r_stall;
  logic [c_STALL_W-1:0]            w_stall_upd;
  logic                            w_halt_hit;
  logic                            w_budget_hit;
  logic [NUM_WATCH-1:0]            r_hit;
  logic [NUM_WATCH-1:0]            w_hit_nxt;
  logic [NUM_WATCH*DATA_WIDTH-1:0] r_data;
  logic [NUM_WATCH*DATA_WIDTH-1:0] w_data_nxt;
  logic                            w_all_match;
  logic                            r_busy;
  logic                            r_done;
  logic                            r_timeout;
  logic                            r_halted;
  logic                            r_pass;

  always_ff @(posedge clock) begin
    if (!resetN) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cycle_inc  = r_cycle + CYCLE_WIDTH'(1);
    w_stall_upd  = '0;
    w_hit_nxt    = r_hit;
    w_data_nxt   = r_data;
    w_all_match  = 1'b1;
    if (r_prev_valid && (bus.pc == r_prev_pc))
      w_stall_upd = (r_stall == c_STALL) ? r_stall : r_stall + c_STALL_W'(1);
    w_halt_hit   = (w_stall_upd == c_STALL);
    w_budget_hit = (w_cycle_inc == c_MAX);
    // Every channel matching the address captures, so shared addresses all update.
    if (r_state == S_RUN) begin
      for (int i = 0; i < NUM_WATCH; i++) begin
        if (bus.memWrite && (bus.memAddress == bus.watchAddress[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
          w_hit_nxt[i]                         = 1'b1;
          w_data_nxt[i*DATA_WIDTH +: DATA_WIDTH] = bus.memWriteData;
        end
      end
    end
    for (int i = 0; i < NUM_WATCH; i++) begin
      if (!w_hit_nxt[i] ||
          (w_data_nxt[i*DATA_WIDTH +: DATA_WIDTH] != bus.expectedData[i*DATA_WIDTH +: DATA_WIDTH]))
        w_all_match = 1'b0;
    end
    case (r_state)
      S_IDLE, S_DONE: if (bus.start) w_state_nxt = S_RUN;
      S_RUN:          if (w_halt_hit || w_budget_hit) w_state_nxt = S_DONE;
      default:        w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      r_cycle      <= '0;
      r_prev_pc    <= '0;
      r_prev_valid <= 1'b0;
      r_stall      <= '0;
      r_hit        <= '0;
      r_data       <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_timeout    <= 1'b0;
      r_halted     <= 1'b0;
      r_pass       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_cycle      <= '0;
            r_prev_valid <= 1'b0;
            r_stall      <= '0;
            r_hit        <= '0;
            r_data       <= '0;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_timeout    <= 1'b0;
            r_halted     <= 1'b0;
            r_pass       <= 1'b0;
          end
        end
        S_RUN: begin
          r_cycle      <= w_cycle_inc;
          r_prev_pc    <= bus.pc;
          r_prev_valid <= 1'b1;
          r_stall      <= w_stall_upd;
          r_hit        <= w_hit_nxt;
          r_data       <= w_data_nxt;
          // Halt takes priority when it coincides with budget exhaustion.
          if (w_halt_hit) begin
            r_halted <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_pass   <= w_all_match;
          end else if (w_budget_hit) begin
            r_timeout <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_pass    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.cpuEnable  = r_busy;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.timeout    = r_timeout;
  assign bus.halted     = r_halted;
  assign bus.pass       = r_pass;
  assign bus.cycleCount = r_cycle;
  assign bus.watchHit   = r_hit;
  assign bus.watchData  = r_data;
endmodule
`default_nettype wire
